// File: rtl/uart_msg_pkg.sv
// Shared constants, state type and ASCII helpers for the UART message sequencer.
// Build option: UART_MSG_HEX_EN selects a hex message counter instead of BCD.
package uart_msg_pkg;

  localparam int unsigned MSG_LEN    = 10;
  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [7:0] CHAR_I  = 8'h49;
  localparam logic [7:0] CHAR_H  = 8'h48;
  localparam logic [7:0] CHAR_P  = 8'h50;
  localparam logic [7:0] CHAR_SP = 8'h20;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_A  = 8'h41;

  typedef enum logic {GAP, SEND} state_e;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return CHAR_0 + {4'h0, n};
    else return CHAR_A + {4'h0, n} - 8'd10;
  endfunction

  // Byte at position idx of "IHP dddd\r\n", digits taken MSB first from cnt.
  function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic [15:0] cnt);
    case (idx)
      4'd0:    return CHAR_I;
      4'd1:    return CHAR_H;
      4'd2:    return CHAR_P;
      4'd3:    return CHAR_SP;
      4'd4:    return nibble_to_ascii(cnt[15:12]);
      4'd5:    return nibble_to_ascii(cnt[11:8]);
      4'd6:    return nibble_to_ascii(cnt[7:4]);
      4'd7:    return nibble_to_ascii(cnt[3:0]);
      4'd8:    return CHAR_CR;
      4'd9:    return CHAR_LF;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/msg_counter4.sv
// Four-digit message counter: BCD by default, 16-bit binary when UART_MSG_HEX_EN is defined.
module msg_counter4
  import uart_msg_pkg::*;
#(
  parameter logic [15:0] START_COUNT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

`ifdef UART_MSG_HEX_EN
  always_comb begin
    count_d = inc ? count_q + 16'd1 : count_q;
  end
`else
  logic carry;

  // Ripple the increment through the digits; a 9 rolls to 0 and carries on.
  always_comb begin
    count_d = count_q;
    carry   = inc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_d[4*i +: 4] = 4'd0;
        end else begin
          count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= START_COUNT;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/uart_msg_seq.sv
// Emits "IHP nnnn\r\n" over a valid/ready byte stream, repeating after an idle gap.
// Build option: UART_MSG_HEX_EN prints the counter as hex (see msg_counter4).
module uart_msg_seq
  import uart_msg_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 1000,
  parameter logic [15:0] START_COUNT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        msg_done,
  output logic [15:0] count
);

  localparam int unsigned   GapW    = $clog2(GAP_CYCLES + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LastIdx = 4'(MSG_LEN - 1);

  state_e          state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            inc;
  logic [15:0]     count_w;

  msg_counter4 #(
    .START_COUNT(START_COUNT)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (inc),
    .count(count_w)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    inc     = 1'b0;
    case (state_q)
      GAP: begin
        if (enable) begin
          if (gap_q == GapLast) begin
            state_d = SEND;
            gap_d   = '0;
            idx_d   = 4'd0;
            data_d  = CHAR_I;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      SEND: begin
        // tx_valid is always high here, so tx_ready alone marks acceptance.
        if (tx_ready) begin
          if (idx_q == LastIdx) begin
            state_d = GAP;
            idx_d   = 4'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            inc     = 1'b1;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = msg_byte(idx_q + 4'd1, count_w);
          end
        end
      end
      default: state_d = GAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= GAP;
      gap_q   <= '0;
      idx_q   <= 4'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_data  = data_q;
  assign tx_valid = valid_q;
  assign busy     = busy_q;
  assign msg_done = done_q;
  assign count    = count_w;

endmodule

// File: tb/tb_uart_msg_seq.sv
// Scoreboard bench: two sequencers (start 0 and start 9999 / 00FF) share all stimulus.
module tb_uart_msg_seq;

`ifdef UART_MSG_HEX_EN
  localparam logic [15:0] START_B = 16'h00FF;
  localparam logic [31:0] B_MSG[5] = '{"00FF", "0100", "0101", "0102", "0103"};
  localparam logic [15:0] B_CNT[5] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104};
`else
  localparam logic [15:0] START_B = 16'h9999;
  localparam logic [31:0] B_MSG[5] = '{"9999", "0000", "0001", "0002", "0003"};
  localparam logic [15:0] B_CNT[5] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
`endif
  localparam logic [31:0] A_MSG[5] = '{"0000", "0001", "0002", "0003", "0004"};
  localparam logic [15:0] A_CNT[5] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
  localparam logic [15:0] STARTS[2] = '{16'h0000, START_B};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  dat[2];
  logic        dvalid[2];
  logic        dbusy[2];
  logic        ddone[2];
  logic [15:0] dcnt[2];

  int total = 0;
  int bad = 0;

  logic [7:0]  bq[2][$];
  logic [15:0] cq[2][$];

  always #5 clk = ~clk;

  uart_msg_seq #(.GAP_CYCLES(4), .START_COUNT(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .tx_data(dat[0]), .tx_valid(dvalid[0]),
    .tx_ready(tx_ready), .busy(dbusy[0]), .msg_done(ddone[0]), .count(dcnt[0])
  );

  uart_msg_seq #(.GAP_CYCLES(4), .START_COUNT(START_B)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .tx_data(dat[1]), .tx_valid(dvalid[1]),
    .tx_ready(tx_ready), .busy(dbusy[1]), .msg_done(ddone[1]), .count(dcnt[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] dg, input bit with_cnt,
                      input logic [15:0] cnt);
    logic [7:0] m[10];
    m = '{8'h49, 8'h48, 8'h50, 8'h20, dg[31:24], dg[23:16], dg[15:8], dg[7:0], 8'h0D, 8'h0A};
    for (int i = 0; i < 10; i++) bq[k].push_back(m[i]);
    if (with_cnt) cq[k].push_back(cnt);
  endtask

  task automatic push_both(input int m, input bit with_cnt);
    push(0, A_MSG[m], with_cnt, A_CNT[m]);
    push(1, B_MSG[m], with_cnt, B_CNT[m]);
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!dvalid[0] && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_msg(input bit bp, input int drop_k, output int vc);
    int k;
    bit done;
    k = 0; done = 1'b0; vc = 0;
    while (!done && k < 300) begin
      if (k == drop_k) enable = 1'b0;
      if (dvalid[0]) vc++;
      tx_ready = bp ? (k % 3 == 2) : 1'b1;
      @(posedge clk); #1;
      k++;
      done = ddone[0];
    end
    tx_ready = 1'b1;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL msg_done_timeout actual=no_pulse required=pulse");
    end
  endtask

  // Monitor: pops expected bytes on each handshake and counts on each msg_done.
  logic       hold[2] = '{1'b0, 1'b0};
  logic [7:0] prev[2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        hold[k] = 1'b0;
      end else begin
        if (hold[k]) chk($sformatf("stall_stable%0d", k), {dvalid[k], dat[k]}, {1'b1, prev[k]});
        if (dvalid[k] && tx_ready) begin
          if (bq[k].size() == 0) begin
            total++; bad++;
            $display("FAIL extra_byte%0d actual=%0h required=none", k, dat[k]);
          end else begin
            chk($sformatf("byte%0d", k), dat[k], bq[k].pop_front());
            chk($sformatf("busy%0d", k), dbusy[k], 1'b1);
          end
        end
        if (ddone[k]) begin
          if (cq[k].size() == 0) begin
            total++; bad++;
            $display("FAIL extra_done%0d actual=%0h required=none", k, dcnt[k]);
          end else begin
            chk($sformatf("count_after_msg%0d", k), dcnt[k], cq[k].pop_front());
            chk($sformatf("valid_low_at_done%0d", k), dvalid[k], 1'b0);
          end
        end
        hold[k] = dvalid[k] && !tx_ready;
        prev[k] = dat[k];
      end
    end
  end

  initial begin
    int e, vc, idle;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid%0d", k), dvalid[k], 1'b0);
      chk($sformatf("rst_data%0d", k), dat[k], 8'h00);
      chk($sformatf("rst_busy%0d", k), dbusy[k], 1'b0);
      chk($sformatf("rst_done%0d", k), ddone[k], 1'b0);
      chk($sformatf("rst_count%0d", k), dcnt[k], STARTS[k]);
    end

    // Full-rate message; tx_valid is visible in the 5th cycle after release.
    enable = 1'b1; tx_ready = 1'b1;
    push_both(0, 1'b1);
    reset = 1'b0;
    wait_valid(e);
    chk("first_valid_latency", e, 4);
    run_msg(1'b0, 0, vc);
    chk("valid_cycles_full_rate", vc, 10);

    // Backpressure 0,0,1: every byte held for three cycles.
    enable = 1'b1;
    push_both(1, 1'b1);
    wait_valid(e);
    chk("gap_latency_bp", e, 4);
    run_msg(1'b1, 0, vc);
    chk("valid_cycles_backpressure", vc, 30);

    // Enable dropped at index 3: message still completes, then the block idles.
    enable = 1'b1;
    push_both(2, 1'b1);
    wait_valid(e);
    chk("gap_latency_drop", e, 4);
    run_msg(1'b0, 3, vc);
    chk("valid_cycles_drop", vc, 10);
    idle = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (dvalid[0] || dvalid[1]) idle++;
    end
    chk("idle_after_disable", idle, 0);
    enable = 1'b1;
    push_both(3, 1'b1);
    wait_valid(e);
    chk("reenable_latency", e, 4);
    run_msg(1'b0, 0, vc);

    // Reset while byte index 6 is on the bus.
    enable = 1'b1;
    push_both(4, 1'b0);
    wait_valid(e);
    chk("gap_latency_rst", e, 4);
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_valid", dvalid[0], 1'b1);
    chk("pre_reset_idx6_0", dat[0], 8'h30);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst_valid%0d", k), dvalid[k], 1'b0);
      chk($sformatf("midrst_busy%0d", k), dbusy[k], 1'b0);
      chk($sformatf("midrst_count%0d", k), dcnt[k], STARTS[k]);
      bq[k].delete();
    end
    @(posedge clk); #1;
    push(0, A_MSG[0], 1'b1, A_CNT[0]);
    push(1, B_MSG[0], 1'b1, B_CNT[0]);
    reset = 1'b0;
    wait_valid(e);
    chk("post_reset_latency", e, 4);
    chk("post_reset_first_byte", dat[0], 8'h49);
    run_msg(1'b0, 0, vc);

    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("leftover_bytes%0d", k), bq[k].size(), 0);
      chk($sformatf("leftover_counts%0d", k), cq[k].size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
